// File: rtl/alu_exec_muldiv.sv
// Execute-stage ALU with an iterative signed mult/div engine owning HI/LO.
// Define ALU_MULDIV_EN to build the engine; otherwise mult/div are inert and HI/LO read as zero.
module alu_exec_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [8:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mfhi,
  input  logic             mflo,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_LUI  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;

  logic [4:0]       shamt;
  logic [3:0]       op;
  logic             is_md;
  logic [WIDTH-1:0] lui_val;
  logic [WIDTH-1:0] alu_res;

  assign shamt   = alu_ctrl[8:4];
  assign op      = alu_ctrl[3:0];
  assign is_md   = (op == OP_MULT) || (op == OP_DIV);
  assign lui_val = WIDTH'(b[15:0]) << 16;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_LUI:  alu_res = lui_val;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      default: alu_res = '0;
    endcase
  end

  // mfhi/mflo take priority over whatever op the decoder supplied
  always_comb begin
    result = alu_res;
    if (mfhi)
      result = hi;
    else if (mflo)
      result = lo;
  end

  assign zero = (result == '0);

`ifdef ALU_MULDIV_EN

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic [WIDTH-1:0]   a_save;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               start;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   q_s;
  logic [WIDTH-1:0]   r_s;

  assign start = in_valid & is_md & (state == S_IDLE);
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // p_lo holds the multiplier (mult) or the dividend being shifted out (div);
  // p_hi is the partial product or the running remainder.
  assign add_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
  assign shifted = {p_hi, p_lo[WIDTH-1]};
  assign diff    = shifted - {1'b0, mcand};

  assign prod   = {p_hi, p_lo};
  assign prod_s = neg_q ? -prod : prod;
  assign q_s    = neg_q ? -p_lo : p_lo;
  assign r_s    = neg_r ? -p_hi : p_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      a_save   <= '0;
      mcand    <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_save   <= a;
            mcand    <= b_mag;
            p_hi     <= '0;
            p_lo     <= a_mag;
            cnt      <= '0;
            is_div   <= (op == OP_DIV);
            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r    <= a[WIDTH-1];
            div_zero <= (op == OP_DIV) && (b == '0);
            state    <= ((op == OP_DIV) && (b == '0)) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          if (is_div) begin
            if (!diff[WIDTH]) begin
              p_hi <= diff[WIDTH-1:0];
              p_lo <= {p_lo[WIDTH-2:0], 1'b1};
            end else begin
              p_hi <= shifted[WIDTH-1:0];
              p_lo <= {p_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            {p_hi, p_lo} <= {add_sum, p_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= S_FIX;
        end
        S_FIX: begin
          if (div_zero) begin
            hi_q <= a_save;
            lo_q <= '1;
          end else if (is_div) begin
            hi_q <= r_s;
            lo_q <= q_s;
          end else begin
            {hi_q, lo_q} <= prod_s;
          end
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign stall = in_valid & (mfhi | mflo | is_md) & busy;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

`else

  logic unused_engine_inputs;
  assign unused_engine_inputs = &{1'b0, clk, reset, in_valid};

  assign busy  = 1'b0;
  assign stall = 1'b0;
  assign done  = 1'b0;
  assign hi    = '0;
  assign lo    = '0;

`endif

endmodule

// File: tb/tb_alu_exec_muldiv.sv
// Scoreboard bench for alu_exec_muldiv: accepted instructions and done pulses are checked by a monitor.
module tb_alu_exec_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [8:0]   alu_ctrl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mfhi;
  logic         mflo;
  logic [W-1:0] result;
  logic         zero;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  alu_exec_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
    .a(a), .b(b), .mfhi(mfhi), .mflo(mflo), .result(result), .zero(zero),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct { string name; logic [W-1:0] res; } res_t;
  typedef struct { string name; logic [W-1:0] hi; logic [W-1:0] lo; } md_t;

  res_t res_q[$];
  md_t  md_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: an instruction is consumed when valid and not stalled; HI/LO are checked on done.
  always @(negedge clk) begin
    res_t er;
    md_t  em;
    if (!reset && in_valid && !stall) begin
      if (res_q.size() == 0) chk("unexpected_accept", 1, 0);
      else begin
        er = res_q.pop_front();
        chk({er.name, "_result"}, result, er.res);
        chk({er.name, "_zero"}, zero, (er.res == '0));
      end
    end
    if (done) begin
      if (md_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        em = md_q.pop_front();
        chk({em.name, "_hi"}, hi, em.hi);
        chk({em.name, "_lo"}, lo, em.lo);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; mfhi = 1'b0; mflo = 1'b0;
    alu_ctrl = '0; a = '0; b = '0;
  endtask

  task automatic drive(input logic [8:0] ctrl, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic fh, input logic fl);
    in_valid = 1'b1; alu_ctrl = ctrl; a = aa; b = bb; mfhi = fh; mflo = fl;
  endtask

  task automatic push_res(input string name, input logic [W-1:0] r);
    res_t e;
    e.name = name; e.res = r;
    res_q.push_back(e);
  endtask

  task automatic push_md(input string name, input logic [W-1:0] h, input logic [W-1:0] l);
    md_t e;
    e.name = name; e.hi = h; e.lo = l;
    md_q.push_back(e);
  endtask

  // Holds the instruction until it is accepted (bounded), then releases the inputs.
  task automatic issue(input string name, input logic [8:0] ctrl, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic fh, input logic fl,
                       input logic [W-1:0] exp);
    drive(ctrl, aa, bb, fh, fl);
    push_res(name, exp);
    for (int n = 0; n <= 100; n++) begin
      @(negedge clk);
      if (!stall) break;
      if (n == 100) chk({name, "_stall_timeout"}, 1, 0);
      tick();
    end
    tick();
    idle_in();
  endtask

  task automatic comb_tests();
    issue("and",      9'h000, 32'h0000F0F0, 32'h0000FF00, 0, 0, 32'h0000F000);
    issue("or",       9'h001, 32'h0000F0F0, 32'h0000FF00, 0, 0, 32'h0000FFF0);
    issue("add",      9'h002, 32'd7,        32'd5,        0, 0, 32'd12);
    issue("add_wrap", 9'h002, 32'hFFFFFFFF, 32'd1,        0, 0, 32'd0);
    issue("sub_zero", 9'h006, 32'd5,        32'd5,        0, 0, 32'd0);
    issue("sub_neg",  9'h006, 32'd3,        32'd5,        0, 0, 32'hFFFFFFFE);
    issue("sll4",     9'h043, 32'd0,        32'd1,        0, 0, 32'd16);
    issue("srl31",    9'h1F4, 32'd0,        32'h80000000, 0, 0, 32'd1);
    issue("lui",      9'h005, 32'd0,        32'hABCD1234, 0, 0, 32'h12340000);
    issue("slt_t",    9'h007, 32'hFFFFFFFF, 32'd1,        0, 0, 32'd1);
    issue("slt_f",    9'h007, 32'd1,        32'hFFFFFFFF, 0, 0, 32'd0);
    issue("slt_min",  9'h007, 32'h80000000, 32'h7FFFFFFF, 0, 0, 32'd1);
    issue("bad_op",   9'h00F, 32'd3,        32'd3,        0, 0, 32'd0);
  endtask

`ifdef ALU_MULDIV_EN
  // Starts a mult/div in cycle 0 and measures busy length and done cycle; optional add at add_at.
  task automatic run_md(input string name, input logic [8:0] ctrl, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input int exp_busy, input int add_at);
    int busy_cnt;
    int done_cyc;
    busy_cnt = 0;
    done_cyc = 0;
    drive(ctrl, aa, bb, 0, 0);
    push_res(name, '0);
    push_md(name, eh, el);
    @(negedge clk);
    chk({name, "_accept_stall"}, stall, 0);
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 1 || k == add_at + 1) idle_in();
      if (k == add_at) begin
        drive(9'h002, 32'd7, 32'd5, 0, 0);
        push_res("add_while_busy", 32'd12);
      end
      @(negedge clk);
      if (k == add_at) chk("add_while_busy_stall", stall, 0);
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    chk({name, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({name, "_done_cycle"}, done_cyc, exp_busy + 1);
    tick();
  endtask

  task automatic mflo_stall_test();
    int stall_cnt;
    int unstall_cyc;
    int done_cyc;
    stall_cnt = 0;
    unstall_cyc = 0;
    done_cyc = 0;
    drive(9'h008, 32'd6, 32'hFFFFFFFC, 0, 0);
    push_res("mult_6x-4", '0);
    push_md("mult_6x-4", 32'hFFFFFFFF, 32'hFFFFFFE8);
    @(negedge clk);
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 1 || (unstall_cyc != 0 && in_valid)) idle_in();
      if (k == 5) begin
        drive(9'h000, '0, '0, 0, 1);
        push_res("mflo_held", 32'hFFFFFFE8);
      end
      @(negedge clk);
      if (k >= 5 && unstall_cyc == 0) begin
        if (stall) stall_cnt++;
        else unstall_cyc = k;
      end
      if (done) done_cyc = k;
      if (done_cyc != 0 && unstall_cyc != 0) break;
    end
    chk("mflo_stall_cycles", stall_cnt, 29);
    chk("mflo_accept_cycle", unstall_cyc, 34);
    chk("mflo_done_cycle", done_cyc, 34);
    tick();
    idle_in();
  endtask

  task automatic reset_abort_test();
    int seen_done;
    seen_done = 0;
    drive(9'h009, 32'd100, 32'd7, 0, 0);
    push_res("div_abort", '0);
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) idle_in();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    for (int k = 0; k < 40; k++) begin
      tick();
      @(negedge clk);
      if (done) seen_done = 1;
    end
    chk("abort_no_done", seen_done, 0);
    tick();
  endtask
`else
  task automatic disabled_test();
    int seen;
    seen = 0;
    issue("mult_off", 9'h008, 32'hFFFFFFFD, 32'd7, 0, 0, 32'd0);
    issue("div0_off", 9'h009, 32'd9, 32'd0, 0, 0, 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy || done) seen = 1;
      tick();
    end
    chk("off_no_busy_done", seen, 0);
    chk("off_hi", hi, 0);
    chk("off_lo", lo, 0);
    issue("mflo_off", 9'h000, '0, '0, 0, 1, 32'd0);
    issue("mfhi_off", 9'h000, '0, '0, 1, 0, 32'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_in();
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick();

    comb_tests();

`ifdef ALU_MULDIV_EN
    run_md("mult_-3x7",  9'h008, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33, 5);
    mflo_stall_test();
    run_md("mult_minsq", 9'h008, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 0);
    issue("mfhi_minsq", 9'h000, '0, '0, 1, 0, 32'h40000000);
    run_md("div_-7/2",   9'h009, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0);
    run_md("div_7/-2",   9'h009, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 0);
    run_md("div_min/-1", 9'h009, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 0);
    run_md("div_9/0",    9'h009, 32'd9,        32'd0,        32'd9,        32'hFFFFFFFF, 1,  0);
    issue("mfhi_dz", 9'h000, '0, '0, 1, 0, 32'd9);
    issue("mflo_dz", 9'h000, '0, '0, 0, 1, 32'hFFFFFFFF);
    reset_abort_test();
    issue("mflo_after_abort", 9'h000, '0, '0, 0, 1, 32'd0);
`else
    disabled_test();
`endif

    tick();
    chk("res_queue_drained", res_q.size(), 0);
    chk("md_queue_drained", md_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
